// File: rtl/norm_round_seq_if.sv
// Operand/result handshake bundle for the normalize-and-round unit.
// The slave modport is the unit itself; the master modport is whoever feeds it.
interface norm_round_seq_if #(
  parameter int nBit = 22,
  parameter int nExp = 7
);
  logic            op_valid;
  logic            op_ready;
  logic            op_sign;
  logic [nExp:0]   op_exp;
  logic [nBit+5:0] op_mant;

  logic            res_valid;
  logic            res_ready;
  logic            res_sign;
  logic [nExp:0]   res_exp;
  logic [nBit:0]   res_frac;
  logic            res_zero;
  logic            res_ovf;
  logic            res_unf;

  modport slave (
    input  op_valid, op_sign, op_exp, op_mant, res_ready,
    output op_ready, res_valid, res_sign, res_exp, res_frac,
           res_zero, res_ovf, res_unf
  );

  modport master (
    output op_valid, op_sign, op_exp, op_mant, res_ready,
    input  op_ready, res_valid, res_sign, res_exp, res_frac,
           res_zero, res_ovf, res_unf
  );
endinterface

// File: rtl/norm_round_seq.sv
// Sequential normalizer and round-to-nearest-even stage: one shift per cycle,
// then a single rounding cycle, then the result is held until accepted.
module norm_round_seq #(
  parameter int nBit = 22,
  parameter int nExp = 7
) (
  input logic               clk,
  input logic               rst,
  norm_round_seq_if.slave   bus
);

  localparam int MW = nBit + 6;
  localparam int EW = nExp + 1;
  localparam int FW = nBit + 1;
  localparam int OVF_BIT = nBit + 5;
  localparam int HID_BIT = nBit + 4;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t          state, state_d;
  logic            sign_q, sign_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic [MW-1:0]   mant_q, mant_d;
  logic            res_sign_q, res_sign_d;
  logic [EW-1:0]   res_exp_q, res_exp_d;
  logic [FW-1:0]   res_frac_q, res_frac_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [EW:0]     exp_inc;
  logic            exp_sat;
  logic [FW-1:0]   frac_field;
  logic            round_up;
  logic [FW:0]     frac_sum;

  // exp_sat flags any increment that lands on (or wraps past) all-ones
  assign exp_inc    = {1'b0, exp_q} + (EW+1)'(1);
  assign exp_sat    = exp_inc[EW] | (&exp_inc[EW-1:0]);
  assign frac_field = mant_q[nBit+3:3];
  assign round_up   = mant_q[2] & (mant_q[3] | mant_q[1] | mant_q[0]);
  assign frac_sum   = {1'b0, frac_field} + {{FW{1'b0}}, round_up};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    res_sign_d = res_sign_q;
    res_exp_d  = res_exp_q;
    res_frac_d = res_frac_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    case (state)
      IDLE: begin
        if (bus.op_valid) begin
          sign_d = bus.op_sign;
          exp_d  = bus.op_exp;
          mant_d = bus.op_mant;
          if (bus.op_mant == '0) begin
            state_d    = DONE;
            res_sign_d = bus.op_sign;
            res_exp_d  = '0;
            res_frac_d = '0;
            zero_d     = 1'b1;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
          end else begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
        if (mant_q[OVF_BIT]) begin
          if (exp_sat) begin
            state_d    = DONE;
            res_sign_d = sign_q;
            res_exp_d  = '1;
            res_frac_d = '0;
            ovf_d      = 1'b1;
          end else begin
            // the bit falling off the bottom is folded into sticky
            mant_d = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
            exp_d  = exp_inc[EW-1:0];
          end
        end else if (!mant_q[HID_BIT]) begin
          if (exp_q == '0) begin
            state_d    = DONE;
            res_sign_d = sign_q;
            res_exp_d  = '0;
            res_frac_d = '0;
            unf_d      = 1'b1;
          end else begin
            mant_d = {mant_q[MW-2:0], 1'b0};
            exp_d  = exp_q - EW'(1);
          end
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        state_d    = DONE;
        res_sign_d = sign_q;
        if (frac_sum[FW]) begin
          res_frac_d = '0;
          if (exp_sat) begin
            res_exp_d = '1;
            ovf_d     = 1'b1;
          end else begin
            res_exp_d = exp_inc[EW-1:0];
          end
        end else begin
          res_exp_d  = exp_q;
          res_frac_d = frac_sum[FW-1:0];
        end
      end

      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
      res_sign_q <= 1'b0;
      res_exp_q  <= '0;
      res_frac_q <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      mant_q     <= mant_d;
      res_sign_q <= res_sign_d;
      res_exp_q  <= res_exp_d;
      res_frac_q <= res_frac_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign bus.op_ready  = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.res_sign  = res_sign_q;
  assign bus.res_exp   = res_exp_q;
  assign bus.res_frac  = res_frac_q;
  assign bus.res_zero  = zero_q;
  assign bus.res_ovf   = ovf_q;
  assign bus.res_unf   = unf_q;

endmodule

// File: doc/norm_round_seq.md
NORM_ROUND_SEQ -- requirements
Module: norm_round_seq

Interface
REQ-001 Parameter nBit, default 22: stored fraction width is nBit+1 bits.
REQ-002 Parameter nExp, default 7: exponent width is nExp+1 bits.
REQ-003 iClk  in  1  single clock; all state changes on its rising edge.
REQ-004 iRst  in  1  reset, synchronous, active-high.
REQ-005 iValid  in  1  upstream operand valid.
REQ-006 oReady  out  1  block can accept an operand; high only in IDLE.
REQ-007 iSign  in  1  operand sign, passed through unchanged.
REQ-008 iExp  in  nExp+1  biased operand exponent.
REQ-009 iMant  in  nBit+6  bit nBit+5 overflow, bit nBit+4 hidden one, bits nBit+3..3 fraction, bits 2..0 guard/round/sticky.
REQ-010 oValid  out  1  result valid; held until accepted.
REQ-011 iReady  in  1  downstream accepts result.
REQ-012 oSign  out  1  result sign.
REQ-013 oExp  out  nExp+1  result exponent.
REQ-014 oFrac  out  nBit+1  result fraction, hidden bit excluded.
REQ-015 oZero  out  1  result is exact zero.
REQ-016 oOvf  out  1  exponent overflow; result forced to infinity.
REQ-017 oUnf  out  1  exponent underflow; result flushed to zero.

Function
REQ-018 FSM states: IDLE, NORM, ROUND, DONE.
REQ-019 Accept occurs on an edge where iValid=1 and oReady=1; iSign, iExp, iMant are captured into internal registers.
REQ-020 On accept, iMant all-zero goes directly to DONE with oZero=1, oExp=0, oFrac=0. Otherwise the block goes to NORM.
REQ-021 NORM, overflow bit set: shift mantissa right one bit, OR the shifted-out bit into bit 0 (sticky), and increment exponent. One cycle per step.
REQ-022 NORM, overflow bit clear and hidden bit clear: shift mantissa left one bit (zero fill) and decrement exponent. One cycle per step.
REQ-023 NORM, hidden bit set and overflow bit clear: go to ROUND. This check costs one cycle.
REQ-024 NORM left shift required while exponent = 0: go to DONE with oUnf=1, oExp=0, oFrac=0.
REQ-025 Any exponent increment that reaches all-ones: go to DONE with oOvf=1, oExp=all-ones, oFrac=0.
REQ-026 ROUND, one cycle, round-to-nearest-even:
  - increment = G when fraction LSB=1;
  - increment = G & (R|S) when fraction LSB=0.
REQ-027 ROUND carry-out of the fraction:
  - fraction = {0, sum[nBit:1]} (all zeros);
  - exponent + 1, subject to the REQ-025 check.
REQ-028 DONE: oValid=1 with outputs stable. Leave DONE for IDLE on an edge where iReady=1; otherwise hold.
REQ-029 oReady=0 in DONE, so an input offered while DONE is accepted no earlier than the following IDLE cycle.
REQ-030 Latency, accept edge to first oValid cycle = 3 + (number of shift steps). A normalized input gives exactly 3.
REQ-031 Maximum shift steps: nBit+4 left, or 1 right.
REQ-032 At most one status flag (oZero, oOvf, oUnf) is high in any cycle.
REQ-033 Status flags are meaningful only while oValid=1 and are 0 otherwise.

Reset
REQ-034 iRst=1 at an edge forces IDLE and takes priority over every other condition, including mid-operation; the in-flight operand is discarded.
REQ-035 Reset values: oReady=1, oValid=0, oSign=0, oExp=0, oFrac=0, oZero=0, oOvf=0, oUnf=0.
REQ-036 No operand is accepted on an edge where iRst=1.

Verification (nBit=22, nExp=7)
REQ-037 Normalized input, iExp=127, frac=0x000001, GRS=000 -> oExp=127, oFrac=0x000001, oValid exactly 3 cycles after accept.
REQ-038 Tie, GRS=100: frac=0x000003 -> oFrac=0x000004; frac=0x000002 -> oFrac=0x000002. GRS=101 with frac=0x000002 -> oFrac=0x000003.
REQ-039 Rounding carry: frac=0x7FFFFF, GRS=110, iExp=100 -> oFrac=0, oExp=101, no flag.
REQ-040 Left normalization: leading one 3 bits below hidden, iExp=10 -> oExp=7, oValid 6 cycles after accept. Same operand with iExp=1 -> oUnf=1, oExp=0, oFrac=0.
REQ-041 Overflow bit set, iExp=254 -> oOvf=1, oExp=255, oFrac=0. iMant=0 -> oZero=1, oValid 1 cycle after accept.
REQ-042 Backpressure and reset:
  - iReady held 0 for 5 cycles -> oValid and outputs stable throughout.
  - iRst pulsed during NORM -> next cycle oReady=1, oValid=0, all outputs 0.
